sobel_radicand_stream: RTL and testbench

Streaming Sobel front end for the edge-magnitude datapath. It accepts an 8-bit grayscale raster one pixel per cycle and builds a 3x3 window using two internal line buffers. For each interior window it computes Gx and Gy, and emits the 16-bit radicand (|Gx|>>2)^2 + (|Gy|>>2)^2, saturated to 16 bits. The output feeds the downstream approximate square-root stage, which takes a 16-bit radicand and produces an 8-bit magnitude.

---
 rtl/sobel_radicand_stream_if.sv | 28 ++
 rtl/sobel_radicand_stream.sv | 171 +++++++++++++++++
 tb/tb_sobel_radicand_stream.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sobel_radicand_stream_if.sv
// Pixel-in / radicand-out stream bundle for the Sobel front end.
// The master side supplies pixels and observes radicands; the slave side is the filter.
interface sobel_radicand_stream_if;
  logic        pix_valid;
  logic        pix_sof;
  logic [7:0]  pix_data;
  logic        rad_valid;
  logic [15:0] rad_data;
  logic        rad_eol;

  modport master (
    output pix_valid,
    output pix_sof,
    output pix_data,
    input  rad_valid,
    input  rad_data,
    input  rad_eol
  );

  modport slave (
    input  pix_valid,
    input  pix_sof,
    input  pix_data,
    output rad_valid,
    output rad_data,
    output rad_eol
  );
endinterface

// File: rtl/sobel_radicand_stream.sv
// Streaming Sobel front end: builds a 3x3 window from two line buffers and
// emits the saturated radicand (|Gx|>>2)^2 + (|Gy|>>2)^2 for every interior
// window, three register stages after the pixel is sampled.
module sobel_radicand_stream #(
  parameter int IMG_WIDTH = 640,
  parameter int COL_W     = 10
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sobel_radicand_stream_if.slave  bus
);

  localparam int               DATA_W   = 8;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(IMG_WIDTH - 1);
  localparam logic [COL_W-1:0] FIRST_IN = COL_W'(2);

  // a + 2b + c for one column/row of the window, always non-negative
  function automatic logic [DATA_W+1:0] tap_sum(input logic [DATA_W-1:0] a,
                                                input logic [DATA_W-1:0] b,
                                                input logic [DATA_W-1:0] c);
    return {2'b00, a} + {1'b0, b, 1'b0} + {2'b00, c};
  endfunction

  // magnitude of a gradient, scaled down by 4 so its square fits in 16 bits
  function automatic logic [7:0] abs_shr2(input logic signed [10:0] g);
    logic [10:0] m;
    m = (g < 0) ? 11'(-g) : 11'(g);
    return 8'(m >> 2);
  endfunction

  // clamp the 17-bit sum of squares to the 16-bit radicand range
  function automatic logic [15:0] sat16(input logic [16:0] s);
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

  logic [COL_W-1:0]  col;
  logic [1:0]        row;
  logic [COL_W-1:0]  pos_col;
  logic [1:0]        pos_row;
  logic [DATA_W-1:0] line1 [IMG_WIDTH];
  logic [DATA_W-1:0] line2 [IMG_WIDTH];
  logic [DATA_W-1:0] lb1_rd;
  logic [DATA_W-1:0] lb2_rd;

  logic [DATA_W-1:0] win_p1 [3][3];
  logic              vld_p1;
  logic              eol_p1;

  logic signed [10:0] gx;
  logic signed [10:0] gy;
  logic [7:0]         a_p2;
  logic [7:0]         b_p2;
  logic               vld_p2;
  logic               eol_p2;

  logic [15:0] sq_a;
  logic [15:0] sq_b;
  logic [16:0] sum_sq;
  logic        rad_valid_p3;
  logic [15:0] rad_data_p3;
  logic        rad_eol_p3;

  // Position of the pixel on the bus: a start-of-frame pixel is always (0,0)
  always_comb begin
    pos_col = bus.pix_sof ? '0 : col;
    pos_row = bus.pix_sof ? 2'd0 : row;
    lb1_rd  = line1[pos_col];
    lb2_rd  = line2[pos_col];
  end

  // Advance column/row on each accepted pixel; row saturates at 2 (interior)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col <= '0;
      row <= 2'd0;
    end else if (bus.pix_valid) begin
      if (pos_col == LAST_COL) begin
        col <= '0;
        row <= (pos_row == 2'd2) ? pos_row : pos_row + 2'd1;
      end else begin
        col <= pos_col + 1'b1;
        row <= pos_row;
      end
    end
  end

  // Line buffers: row r-1 moves down to line2, new pixel lands in line1
  always_ff @(posedge clk) begin
    if (bus.pix_valid) begin
      line2[pos_col] <= lb1_rd;
      line1[pos_col] <= bus.pix_data;
    end
  end

  // ---- stage 1: window shift and interior flag ----
  // Shift the window left on accept and tag interior positions
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      eol_p1 <= 1'b0;
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win_p1[i][j] <= '0;
    end else begin
      vld_p1 <= bus.pix_valid && (pos_row == 2'd2) && (pos_col >= FIRST_IN);
      eol_p1 <= bus.pix_valid && (pos_row == 2'd2) && (pos_col == LAST_COL);
      if (bus.pix_valid) begin
        for (int i = 0; i < 3; i++) begin
          win_p1[i][0] <= win_p1[i][1];
          win_p1[i][1] <= win_p1[i][2];
        end
        win_p1[0][2] <= lb2_rd;
        win_p1[1][2] <= lb1_rd;
        win_p1[2][2] <= bus.pix_data;
      end
    end
  end

  // ---- stage 2: gradients, magnitude, scale ----
  // Gradients are right-minus-left and bottom-minus-top of the window
  always_comb begin
    gx = $signed({1'b0, tap_sum(win_p1[0][2], win_p1[1][2], win_p1[2][2])})
       - $signed({1'b0, tap_sum(win_p1[0][0], win_p1[1][0], win_p1[2][0])});
    gy = $signed({1'b0, tap_sum(win_p1[2][0], win_p1[2][1], win_p1[2][2])})
       - $signed({1'b0, tap_sum(win_p1[0][0], win_p1[0][1], win_p1[0][2])});
  end

  // Control for stage 2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p2 <= 1'b0;
      eol_p2 <= 1'b0;
    end else begin
      vld_p2 <= vld_p1;
      eol_p2 <= eol_p1;
    end
  end

  // Scaled magnitudes; free-running data, qualified by vld_p2
  always_ff @(posedge clk) begin
    a_p2 <= abs_shr2(gx);
    b_p2 <= abs_shr2(gy);
  end

  // ---- stage 3: squares, sum, saturation ----
  // Sum of squares needs 17 bits before clamping
  always_comb begin
    sq_a   = a_p2 * a_p2;
    sq_b   = b_p2 * b_p2;
    sum_sq = {1'b0, sq_a} + {1'b0, sq_b};
  end

  // Output registers; rad_data holds between pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rad_valid_p3 <= 1'b0;
      rad_eol_p3   <= 1'b0;
      rad_data_p3  <= '0;
    end else begin
      rad_valid_p3 <= vld_p2;
      rad_eol_p3   <= vld_p2 && eol_p2;
      if (vld_p2)
        rad_data_p3 <= sat16(sum_sq);
    end
  end

  assign bus.rad_valid = rad_valid_p3;
  assign bus.rad_data  = rad_data_p3;
  assign bus.rad_eol   = rad_eol_p3;

endmodule

// File: tb/tb_sobel_radicand_stream.sv
// Directed bench for sobel_radicand_stream with an 8-pixel-wide raster.
// The driver pushes hand-derived expectations; a negedge monitor pops them.
module tb_sobel_radicand_stream;
  localparam int W = 8;

  typedef struct {
    logic [15:0] data;
    logic        eol;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sobel_radicand_stream_if bus();

  sobel_radicand_stream #(.IMG_WIDTH(W), .COL_W(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   cyc    = 0;
  int   n_cmp  = 0;
  int   n_bad  = 0;
  int   pulses = 0;

  // Hand-computed radicands for row 2 of the saturation frame, by producing column
  logic [15:0] sat_row [W] = '{16'd0, 16'd0, 16'hFFFF, 16'd16129,
                               16'hFFFF, 16'd65025, 16'd65025, 16'd65025};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", nm, act, req, $time);
    end
  endtask

  // kind 0: flat 100; kind 1: vertical edge between col 3 and 4; kind 2: row 2 / col 2 = 255
  function automatic logic [7:0] pix_val(input int kind, input int r, input int c);
    case (kind)
      0:       return 8'd100;
      1:       return (c >= 4) ? 8'd255 : 8'd0;
      default: return (r == 2 || c == 2) ? 8'd255 : 8'd0;
    endcase
  endfunction

  function automatic logic [15:0] exp_val(input int kind, input int c);
    case (kind)
      0:       return 16'd0;
      1:       return (c == 4 || c == 5) ? 16'd65025 : 16'd0;
      default: return sat_row[c];
    endcase
  endfunction

  task automatic frame(input int kind, input int n_pix, input bit gap,
                       input bit sof, input bit last_idle);
    for (int p = 0; p < n_pix; p++) begin
      int r;
      int c;
      exp_t e;
      r = p / W;
      c = p % W;
      @(posedge clk); #1;
      bus.pix_valid = 1'b1;
      bus.pix_sof   = sof && (p == 0);
      bus.pix_data  = pix_val(kind, r, c);
      if (r >= 2 && c >= 2) begin
        e.data = exp_val(kind, c);
        e.eol  = (c == W - 1);
        e.cyc  = cyc + 3;
        exp_q.push_back(e);
      end
      if (gap) begin
        @(posedge clk); #1;
        bus.pix_valid = 1'b0;
        bus.pix_sof   = 1'b0;
        bus.pix_data  = 8'hA5;
      end
    end
    if (last_idle) begin
      @(posedge clk); #1;
      bus.pix_valid = 1'b0;
      bus.pix_sof   = 1'b0;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
    repeat (3) @(posedge clk);
    #1;
    chk("drain_left", exp_q.size(), 0);
  endtask

  // Monitor: every output pulse must match the oldest expectation, on its cycle
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.rad_valid) begin
      pulses++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", 1, 0);
      end else begin
        e = exp_q.pop_front();
        chk("rad_data", int'(bus.rad_data), int'(e.data));
        chk("rad_eol", int'(bus.rad_eol), int'(e.eol));
        chk("latency_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.pix_valid = 1'b0;
    bus.pix_sof   = 1'b0;
    bus.pix_data  = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_valid", int'(bus.rad_valid), 0);
    chk("reset_data", int'(bus.rad_data), 0);
    chk("reset_eol", int'(bus.rad_eol), 0);
    rst_n = 1'b1;

    // flat frame, first frame after reset needs no sof
    pulses = 0;
    frame(0, 5 * W, 1'b0, 1'b0, 1'b1);
    drain();
    chk("flat_pulses", pulses, 18);

    // vertical edge
    pulses = 0;
    frame(1, 4 * W, 1'b0, 1'b1, 1'b1);
    drain();
    chk("edge_pulses", pulses, 12);

    // saturation window, then hold of the last value
    frame(2, 3 * W, 1'b0, 1'b1, 1'b1);
    drain();
    chk("hold_valid", int'(bus.rad_valid), 0);
    chk("hold_data", int'(bus.rad_data), 65025);

    // gapped vertical edge
    pulses = 0;
    frame(1, 4 * W, 1'b1, 1'b1, 1'b1);
    drain();
    chk("gap_pulses", pulses, 12);

    // sof at (3,5): 9 outputs from the old frame, 6 from the new one
    pulses = 0;
    frame(1, 3 * W + 5, 1'b0, 1'b1, 1'b0);
    frame(1, 3 * W, 1'b0, 1'b1, 1'b1);
    drain();
    chk("sof_pulses", pulses, 15);

    // reset during row 3 while an output is on the bus
    frame(1, 3 * W + 6, 1'b0, 1'b1, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("pre_rst_valid", int'(bus.rad_valid), 1);
    chk("pre_rst_data", int'(bus.rad_data), 65025);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", int'(bus.rad_valid), 0);
    chk("async_rst_data", int'(bus.rad_data), 0);
    chk("async_rst_eol", int'(bus.rad_eol), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    pulses = 0;
    frame(1, 3 * W, 1'b0, 1'b0, 1'b1);
    drain();
    chk("post_rst_pulses", pulses, 6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
